transport_send: RTL and testbench

TRANSPORT_SEND -- requirements
Module: transport_send

---
 rtl/transport_send.sv | 182 ++++++++++++++++++
 tb/tb_transport_send.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/transport_send.sv
// transport_send: packetizes session words into fixed-size byte packets for the network.
//   clk, reset        : clock, synchronous active-high reset
//   sess_kind/data    : one-cycle strobe (01 control word, 10 audio word) with its 16-bit word
//   ctrl_ready        : control holding register is empty
//   audio_ready       : audio FIFO has room
//   tx_data/valid/sop : registered byte stream to network, sop marks the header byte
//   tx_ready          : network accepts the presented byte
//   busy              : packet in progress
//   overflow          : sticky, a strobe was dropped because its ready was low
module transport_send #(
  parameter int PACKET_SIZE = 16,
  parameter int AUDIO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  sess_kind,
  input  logic [15:0] sess_data,
  output logic        ctrl_ready,
  output logic        audio_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_sop,
  output logic        busy,
  output logic        overflow
);

  localparam int W  = (PACKET_SIZE - 2) / 2;
  localparam int PW = (AUDIO_DEPTH > 1) ? $clog2(AUDIO_DEPTH) : 1;
  localparam int CW = $clog2(AUDIO_DEPTH + 1);
  localparam int BW = $clog2(PACKET_SIZE);

  typedef enum logic [2:0] {IDLE, HDR, CTRL_HI, CTRL_LO, AUD_HI, AUD_LO, PAD} state_t;

  state_t          state_q;
  logic            pkt_ctrl_q;
  logic [BW-1:0]   byte_cnt_q;
  logic [7:0]      tx_data_q;
  logic            tx_valid_q;
  logic            tx_sop_q;
  logic            overflow_q;
  logic            hold_full_q;
  logic [15:0]     hold_q;
  logic [15:0]     shadow_q;
  logic [15:0]     mem_q [AUDIO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic ctrl_push, audio_push, drop, accept, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(AUDIO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ready flags reflect state before this cycle's pop/start, so a strobe
  // arriving alongside a pop or a packet start still sees the old occupancy.
  assign ctrl_ready  = !hold_full_q;
  assign audio_ready = (count_q < CW'(AUDIO_DEPTH));
  assign ctrl_push   = (sess_kind == 2'b01) && ctrl_ready;
  assign audio_push  = (sess_kind == 2'b10) && audio_ready;
  assign drop        = ((sess_kind == 2'b01) && !ctrl_ready) ||
                       ((sess_kind == 2'b10) && !audio_ready);
  assign accept      = tx_valid_q && tx_ready;
  assign pop         = accept && (state_q == AUD_LO);
  assign rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  assign count_d     = count_q + CW'(audio_push) - CW'(pop);

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign tx_sop   = tx_sop_q;
  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;

  // Audio FIFO storage (data, no reset) and its control pointers.
  always_ff @(posedge clk) begin
    if (audio_push) mem_q[wr_ptr_q] <= sess_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (audio_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Control holding register; it is freed when a control packet starts,
  // which can never coincide with a load because ctrl_ready is low then.
  always_ff @(posedge clk) begin
    if (ctrl_push) hold_q <= sess_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && hold_full_q) hold_full_q <= 1'b0;
      if (ctrl_push) hold_full_q <= 1'b1;
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Packet FSM with registered byte outputs: each branch loads the byte
  // that the next state presents, so tx_data only changes on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pkt_ctrl_q <= 1'b0;
      byte_cnt_q <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_sop_q   <= 1'b0;
    end else begin
      if (state_q != IDLE && accept) byte_cnt_q <= byte_cnt_q + BW'(1);
      case (state_q)
        IDLE: begin
          byte_cnt_q <= '0;
          if (hold_full_q) begin
            state_q    <= HDR;
            pkt_ctrl_q <= 1'b1;
            shadow_q   <= hold_q;
            tx_data_q  <= 8'h40;
            tx_valid_q <= 1'b1;
            tx_sop_q   <= 1'b1;
          end else if (count_q >= CW'(W)) begin
            state_q    <= HDR;
            pkt_ctrl_q <= 1'b0;
            tx_data_q  <= 8'h80;
            tx_valid_q <= 1'b1;
            tx_sop_q   <= 1'b1;
          end
        end
        HDR: if (accept) begin
          tx_sop_q <= 1'b0;
          if (pkt_ctrl_q) begin
            state_q   <= CTRL_HI;
            tx_data_q <= shadow_q[15:8];
          end else begin
            state_q   <= AUD_HI;
            tx_data_q <= mem_q[rd_ptr_q][15:8];
          end
        end
        CTRL_HI: if (accept) begin
          state_q   <= CTRL_LO;
          tx_data_q <= shadow_q[7:0];
        end
        CTRL_LO: if (accept) begin
          state_q   <= PAD;
          tx_data_q <= 8'h00;
        end
        AUD_HI: if (accept) begin
          state_q   <= AUD_LO;
          tx_data_q <= mem_q[rd_ptr_q][7:0];
        end
        AUD_LO: if (accept) begin
          // The low byte of word W sits at byte index PACKET_SIZE-2.
          if (byte_cnt_q == BW'(PACKET_SIZE - 2)) begin
            state_q   <= PAD;
            tx_data_q <= 8'h00;
          end else begin
            state_q   <= AUD_HI;
            tx_data_q <= mem_q[rd_ptr_d][15:8];
          end
        end
        PAD: if (accept) begin
          tx_data_q <= 8'h00;
          if (byte_cnt_q == BW'(PACKET_SIZE - 1)) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_transport_send.sv
module tb_transport_send;
  localparam int PS = 16;
  localparam int AD = 16;
  localparam int W  = (PS - 2) / 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sess_kind;
  logic [15:0] sess_data;
  logic        ctrl_ready, audio_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, tx_sop, busy, overflow;

  always #5 clk = ~clk;

  transport_send #(.PACKET_SIZE(PS), .AUDIO_DEPTH(AD)) dut (
    .clk(clk), .reset(reset), .sess_kind(sess_kind), .sess_data(sess_data),
    .ctrl_ready(ctrl_ready), .audio_ready(audio_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_sop(tx_sop), .busy(busy),
    .overflow(overflow)
  );

  // Reference model: the packet in flight is a queue of bytes to deliver,
  // each tagged with whether it is the header and whether delivering it
  // retires an audio word.
  typedef struct {
    logic [7:0] b;
    bit         sop;
    bit         pop;
  } ent_t;

  ent_t        m_pkt[$];
  logic [15:0] m_aud[$];
  bit          m_hold_v;
  logic [15:0] m_hold;
  bit          m_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [7:0] b, input bit sop, input bit pop);
    ent_t e;
    e.b = b; e.sop = sop; e.pop = pop;
    return e;
  endfunction

  function automatic void build_ctrl(input logic [15:0] w);
    m_pkt.delete();
    m_pkt.push_back(mk(8'h40, 1'b1, 1'b0));
    m_pkt.push_back(mk(w[15:8], 1'b0, 1'b0));
    m_pkt.push_back(mk(w[7:0], 1'b0, 1'b0));
    for (int i = 3; i < PS; i++) m_pkt.push_back(mk(8'h00, 1'b0, 1'b0));
  endfunction

  function automatic void build_aud();
    logic [15:0] w;
    m_pkt.delete();
    m_pkt.push_back(mk(8'h80, 1'b1, 1'b0));
    for (int i = 0; i < W; i++) begin
      w = m_aud[i];
      m_pkt.push_back(mk(w[15:8], 1'b0, 1'b0));
      m_pkt.push_back(mk(w[7:0], 1'b0, 1'b1));
    end
    m_pkt.push_back(mk(8'h00, 1'b0, 1'b0));
  endfunction

  function automatic void model_edge();
    bit   cr, ar;
    ent_t e;
    if (reset) begin
      m_pkt.delete(); m_aud.delete();
      m_hold_v = 0; m_ovf = 0;
      return;
    end
    cr = !m_hold_v;
    ar = (m_aud.size() < AD);
    if (m_pkt.size() > 0) begin
      if (tx_ready) begin
        e = m_pkt.pop_front();
        if (e.pop) void'(m_aud.pop_front());
      end
    end else if (m_hold_v) begin
      build_ctrl(m_hold);
      m_hold_v = 0;
    end else if (m_aud.size() >= W) begin
      build_aud();
    end
    if (sess_kind == 2'b01) begin
      if (cr) begin m_hold = sess_data; m_hold_v = 1; end
      else m_ovf = 1;
    end else if (sess_kind == 2'b10) begin
      if (ar) m_aud.push_back(sess_data);
      else m_ovf = 1;
    end
  endfunction

  task automatic check_all();
    bit v;
    v = (m_pkt.size() > 0);
    chk("tx_valid", tx_valid, v);
    if (v) begin
      chk("tx_data", tx_data, m_pkt[0].b);
      chk("tx_sop", tx_sop, m_pkt[0].sop);
    end else begin
      chk("tx_sop_idle", tx_sop, 0);
    end
    chk("busy", busy, v);
    chk("ctrl_ready", ctrl_ready, !m_hold_v);
    chk("audio_ready", audio_ready, m_aud.size() < AD);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic cyc(input logic [1:0] k, input logic [15:0] d, input logic r, input logic rst);
    sess_kind = k; sess_data = d; tx_ready = r; reset = rst;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) cyc(2'b00, 16'h0000, r, 1'b0);
  endtask

  initial begin
    int guard;
    logic [15:0] w;
    sess_kind = 2'b00; sess_data = 16'h0; tx_ready = 1'b1; reset = 1'b1;

    // Reset state
    cyc(2'b00, 16'h0, 1'b1, 1'b1);
    cyc(2'b00, 16'h0, 1'b1, 1'b1);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_ctrl_ready", ctrl_ready, 1);
    chk("rst_audio_ready", audio_ready, 1);
    chk("rst_overflow", overflow, 0);
    idle(2, 1'b1);

    // Single control packet, header one edge after the strobe edge
    cyc(2'b01, 16'hBEEF, 1'b1, 1'b0);
    chk("ctrl_pre_hdr", tx_valid, 0);
    idle(1, 1'b1);
    chk("ctrl_hdr_latency", tx_data, 8'h40);
    chk("ctrl_hdr_sop", tx_sop, 1);
    idle(1, 1'b1);
    chk("ctrl_hi", tx_data, 8'hBE);
    idle(1, 1'b1);
    chk("ctrl_lo", tx_data, 8'hEF);
    idle(20, 1'b1);

    // Seven audio words -> one audio packet, FIFO drained
    for (int i = 1; i <= 7; i++) begin
      w = {i[7:0], i[7:0]};
      cyc(2'b10, w, 1'b1, 1'b0);
    end
    idle(1, 1'b1);
    chk("aud_hdr", tx_data, 8'h80);
    idle(20, 1'b1);
    chk("aud_drained_ready", audio_ready, 1);

    // Control priority over partly filled FIFO, then audio after gap
    for (int i = 1; i <= 6; i++) cyc(2'b10, 16'h1100 + 16'(i), 1'b1, 1'b0);
    cyc(2'b01, 16'h1234, 1'b1, 1'b0);
    cyc(2'b10, 16'h1107, 1'b1, 1'b0);
    chk("prio_ctrl_first", tx_data, 8'h40);
    idle(40, 1'b1);

    // Backpressure toggling during a control packet
    cyc(2'b01, 16'hA55A, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) cyc(2'b00, 16'h0, 1'(i % 2), 1'b0);

    // FIFO fill with network stalled -> 17th strobe dropped, overflow sticky
    for (int i = 0; i < 17; i++) cyc(2'b10, 16'h2000 + 16'(i), 1'b0, 1'b0);
    chk("fill_audio_ready", audio_ready, 0);
    chk("fill_overflow", overflow, 1);
    idle(60, 1'b1);
    chk("ovf_sticky", overflow, 1);
    cyc(2'b00, 16'h0, 1'b1, 1'b1);
    chk("ovf_cleared", overflow, 0);

    // Reset mid audio packet at byte 5
    for (int i = 0; i < 7; i++) cyc(2'b10, 16'h3000 + 16'(i), 1'b1, 1'b0);
    guard = 0;
    while (!(m_pkt.size() == PS - 5) && guard < 40) begin
      idle(1, 1'b1);
      guard++;
    end
    chk("reach_byte5", (guard < 40), 1);
    cyc(2'b00, 16'h0, 1'b1, 1'b1);
    chk("abort_valid", tx_valid, 0);
    chk("abort_audio_ready", audio_ready, 1);
    chk("abort_ctrl_ready", ctrl_ready, 1);
    idle(30, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic [1:0] k;
      r = $urandom_range(0, 9);
      k = (r < 5) ? 2'b10 : (r < 6) ? 2'b01 : 2'(r);
      cyc(k, 16'($urandom), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 599) == 0));
    end
    idle(60, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
